// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: on a start pulse, walks register indices 0..NUM_REGS-1
// through one register-file read port. Each register goes out as a frame of
// one index byte followed by its data bytes, most significant byte first,
// over a valid/ready byte stream. The core is held halted for the whole dump.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             one-cycle dump request, ignored while busy
//   rd_addr/rd_data   register-file read port (combinational data)
//   tx_data/tx_valid  byte stream out; held stable until tx_ready
//   tx_ready          downstream accepts the byte
//   busy, cpu_halt    dump in progress (identical)
//   done              one-cycle pulse after the final byte is accepted
module regfile_dump_tx #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              cpu_halt,
  output logic              done
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SH_W  = DATA_W + 8;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [SH_W-1:0]   r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic [SH_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [7:0]        w_tx_data_nxt;
  logic              w_tx_valid_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [7:0]        w_idx_byte;
  logic              w_hs;

  assign w_idx_byte = 8'(r_rd_addr);
  assign w_hs       = r_tx_valid & tx_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_addr_nxt  = r_rd_addr;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rd_addr_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_READ;
        end
      end

      // rd_addr has been stable for a full cycle, so rd_data is the word to frame
      S_READ: begin
        w_shift_nxt    = {w_idx_byte, rd_data};
        w_tx_data_nxt  = w_idx_byte;
        w_tx_valid_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = S_SEND;
      end

      // The byte on tx_data is always the top byte of r_shift
      S_SEND: begin
        if (w_hs) begin
          if (r_cnt == LAST_CNT) begin
            w_tx_valid_nxt = 1'b0;
            if (r_rd_addr == LAST_ADDR) begin
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
              w_state_nxt   = S_READ;
            end
          end else begin
            w_cnt_nxt     = r_cnt + CNT_W'(1);
            w_shift_nxt   = r_shift << 8;
            w_tx_data_nxt = r_shift[SH_W-9 -: 8];
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd_addr  = r_rd_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign cpu_halt = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: expected byte streams are queued when a dump is
// launched; independent monitors pop and compare on every accepted byte.
module tb_regfile_dump_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        cpu_halt;
  logic        done;

  logic        start_s;
  logic [4:0]  rd_addr_s;
  logic [15:0] rd_data_s;
  logic [7:0]  tx_data_s;
  logic        tx_valid_s;
  logic        tx_ready_s;
  logic        busy_s;
  logic        cpu_halt_s;
  logic        done_s;

  logic [31:0] regs   [32];
  logic [15:0] regs_s [4];

  assign rd_data   = regs[rd_addr];
  assign rd_data_s = regs_s[rd_addr_s[1:0]];

  regfile_dump_tx u_dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cpu_halt(cpu_halt), .done(done)
  );

  regfile_dump_tx #(.NUM_REGS(4), .ADDR_W(5), .DATA_W(16)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready_s),
    .busy(busy_s), .cpu_halt(cpu_halt_s), .done(done_s)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] q  [$];
  logic [7:0] qs [$];
  int n_bytes, n_done, n_busy, done_cyc;
  int n_bytes_s, n_done_s, done_cyc_s;
  bit bp_mode = 0;
  int bp_ph   = 0;
  logic [3:0] bp_pat = 4'b1001;  // ready sequence 1,0,0,1

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard for the default-parameter instance
  initial begin
    bit         prev_stall = 0;
    bit         prev_rst   = 1;
    logic [7:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      check("cpu_halt_eq_busy", 32'(cpu_halt), 32'(busy));
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (prev_stall && !prev_rst) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        n_bytes++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_byte: got %0h required no byte", tx_data);
        end else begin
          check("byte", 32'(tx_data), 32'(q.pop_front()));
        end
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data  = tx_data;
      prev_rst   = (rst === 1'b1);
    end
  end

  // Monitor / scoreboard for the small instance
  initial forever begin
    @(negedge clk);
    if (done_s === 1'b1) begin
      n_done_s++;
      done_cyc_s = cyc;
    end
    if (tx_valid_s === 1'b1 && tx_ready_s === 1'b1) begin
      n_bytes_s++;
      if (qs.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL small_extra_byte: got %0h required no byte", tx_data_s);
      end else begin
        check("small_byte", 32'(tx_data_s), 32'(qs.pop_front()));
      end
    end
  end

  task automatic push_frame(input int idx, input logic [31:0] d);
    q.push_back(8'(idx));
    for (int b = 3; b >= 0; b--) q.push_back(d[8*b +: 8]);
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++) push_frame(i, regs[i]);
  endtask

  task automatic reset_counts();
    n_bytes  = 0;
    n_done   = 0;
    n_busy   = 0;
    done_cyc = 0;
  endtask

  task automatic drive_ready();
    if (bp_mode) begin
      tx_ready = bp_pat[bp_ph];
      bp_ph    = (bp_ph + 1) % 4;
    end else begin
      tx_ready = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive_ready();
    end
  endtask

  // Pulse start, check launch latency, then wait for n_want done pulses.
  task automatic do_dump(input int n_want, input int budget, input int restart_at,
                         input bit b2b, output int t0);
    bit ok;
    bit b2b_left;
    b2b_left = b2b;
    ok       = 0;
    @(posedge clk); #1; start = 1'b1; drive_ready();
    @(posedge clk); #1; start = 1'b0; drive_ready();
    t0 = cyc;
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_addr", 32'(rd_addr), 32'd0);
    check("launch_valid", 32'(tx_valid), 32'd0);
    for (int k = 0; k < budget; k++) begin
      if (n_done >= n_want) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1; drive_ready();
      if (k == 0) begin
        check("first_valid", 32'(tx_valid), 32'd1);
        check("first_idx", 32'(tx_data), 32'h00);
      end
      start = (k == restart_at) || (b2b_left && done === 1'b1);
      if (b2b_left && done === 1'b1) b2b_left = 0;
    end
    check("dump_completed", 32'(ok), 32'd1);
    start = 1'b0;
  endtask

  initial begin
    int  t0;
    bit  ok;
    rst        = 1'b1;
    start      = 1'b0;
    start_s    = 1'b0;
    tx_ready   = 1'b1;
    tx_ready_s = 1'b1;
    n_bytes_s  = 0;
    n_done_s   = 0;
    done_cyc_s = 0;
    reset_counts();
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 4; i++)  regs_s[i] = 16'hBEE0 + 16'(i);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_halt", 32'(cpu_halt), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Full dump, ready tied high
    reset_counts();
    push_dump();
    do_dump(1, 400, -1, 0, t0);
    idle_cycles(3);
    check("full_done_latency", 32'(done_cyc - t0), 32'd192);
    check("full_bytes", 32'(n_bytes), 32'd160);
    check("full_done_count", 32'(n_done), 32'd1);
    check("full_busy_cycles", 32'(n_busy), 32'd192);
    check("full_queue_empty", 32'(q.size()), 32'd0);

    // Backpressure, ready pattern 1,0,0,1
    regs[5] = 32'hDEAD_BEEF;
    reset_counts();
    push_dump();
    bp_mode = 1;
    bp_ph   = 0;
    do_dump(1, 1500, -1, 0, t0);
    bp_mode = 0;
    idle_cycles(3);
    check("bp_bytes", 32'(n_bytes), 32'd160);
    check("bp_done_count", 32'(n_done), 32'd1);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Start pulsed again mid-dump is ignored
    reset_counts();
    push_dump();
    do_dump(1, 400, 50, 0, t0);
    idle_cycles(5);
    check("restart_bytes", 32'(n_bytes), 32'd160);
    check("restart_done_count", 32'(n_done), 32'd1);
    check("restart_not_queued", 32'(busy), 32'd0);

    // Reset while byte 3 of register 7 is pending
    reset_counts();
    for (int i = 0; i < 7; i++) push_frame(i, regs[i]);
    q.push_back(8'h07);
    q.push_back(regs[7][31:24]);
    @(posedge clk); #1; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (n_bytes == 37) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mid_reached_reg7", 32'(ok), 32'd1);
    tx_ready = 1'b0;
    check("mid_pending_valid", 32'(tx_valid), 32'd1);
    check("mid_pending_data", 32'(tx_data), 32'(regs[7][23:16]));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_valid", 32'(tx_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rd_addr", 32'(rd_addr), 32'd0);
    idle_cycles(10);
    check("mid_no_done", 32'(n_done), 32'd0);
    check("mid_bytes", 32'(n_bytes), 32'd37);
    check("mid_queue_empty", 32'(q.size()), 32'd0);

    // Fresh dump after the abort starts at index 0
    reset_counts();
    push_dump();
    do_dump(1, 400, -1, 0, t0);
    idle_cycles(3);
    check("after_rst_bytes", 32'(n_bytes), 32'd160);
    check("after_rst_done", 32'(n_done), 32'd1);

    // Back-to-back: start in the done-pulse cycle
    reset_counts();
    push_dump();
    push_dump();
    do_dump(2, 800, -1, 1, t0);
    idle_cycles(3);
    check("b2b_bytes", 32'(n_bytes), 32'd320);
    check("b2b_done_count", 32'(n_done), 32'd2);
    check("b2b_queue_empty", 32'(q.size()), 32'd0);

    // Small instance: 4 registers of 16 bits
    for (int i = 0; i < 4; i++) begin
      qs.push_back(8'(i));
      qs.push_back(8'hBE);
      qs.push_back(8'hE0 + 8'(i));
    end
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    t0 = cyc;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (n_done_s >= 1) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    idle_cycles(3);
    check("small_completed", 32'(ok), 32'd1);
    check("small_done_latency", 32'(done_cyc_s - t0), 32'd16);
    check("small_bytes", 32'(n_bytes_s), 32'd12);
    check("small_done_count", 32'(n_done_s), 32'd1);
    check("small_queue_empty", 32'(qs.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Debug read-out engine on the far side of the 32x32 register file's read port.
- On a start pulse, walks register indices 0..NUM_REGS-1 through one read port and captures each word.
- Emits each word as a framed byte stream over a valid/ready interface into the board UART transmitter.
- Holds the core halted for the whole dump, so the dump is a consistent snapshot of the register file.

Parameters:
- NUM_REGS, 32, number of registers dumped; indices 0..NUM_REGS-1.
- ADDR_W, 5, register index width; requires NUM_REGS <= 2**ADDR_W and ADDR_W <= 8.
- DATA_W, 32, register width; must be a multiple of 8. BYTES = DATA_W/8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; ignored while busy.
- rd_addr  out  ADDR_W  registered index driven to the register file read port (A1/A2 style).
- rd_data  in  DATA_W  combinational read data for rd_addr; valid in the same cycle.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid; held with tx_data stable until accepted.
- tx_ready  in  1  transmitter accepts the byte; a transfer occurs when tx_valid & tx_ready at posedge.
- busy  out  1  high from the cycle after start is accepted until the dump ends.
- cpu_halt  out  1  equal to busy; stalls the core so the register file is not written mid-dump.
- done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - rd_addr=0, tx_data=0, tx_valid=0, busy=0, cpu_halt=0, done=0.
  - Byte counter and shift register are cleared.
  - Applies mid-dump: the dump aborts with no further bytes and no done pulse; tx_valid is low from the following cycle.
- Frame per register: BYTES+1 bytes, sent in this order.
  - Index byte: zero-extended rd_addr.
  - Data bytes, most significant first. Default is 5 bytes: idx, d[31:24], d[23:16], d[15:8], d[7:0].
- FSM states: IDLE, READ, SEND.
- IDLE:
  - done=0 except for the single pulse cycle.
  - On start=1: rd_addr<=0, busy<=1, state<=READ.
- READ (exactly one cycle; rd_addr is stable and rd_data is valid):
  - Shift register <= {idx byte, rd_data}.
  - tx_data<=idx byte, tx_valid<=1, byte counter<=0.
  - state<=SEND.
- SEND:
  - On each handshake, the counter increments and tx_data advances to the next byte, with tx_valid kept at 1.
  - No handshake means no change. tx_data must not change while tx_valid=1 and tx_ready=0.
  - On the handshake of the last byte (counter == BYTES), tx_valid<=0, then:
    - If rd_addr == NUM_REGS-1: state<=IDLE, busy<=0, done<=1 for one cycle, rd_addr held.
    - Otherwise: rd_addr<=rd_addr+1, state<=READ.
- Latency and throughput:
  - start accepted at edge N means busy=1 and rd_addr=0 from N.
  - First tx_valid=1 from edge N+1.
  - With tx_ready tied high, each register costs BYTES+2 cycles (1 READ, BYTES+1 SEND). The default dump is 32*6=192 cycles from start to done.
- tx_ready is ignored when tx_valid=0.
- start while busy is ignored, not queued. start in the same cycle as the done pulse is accepted, since the state is already IDLE.
- rd_addr never exceeds NUM_REGS-1; there is no wrap.

Test Plan:
- Reset sequence: rst=1 for 2 cycles, then start=1 for 1 cycle, tx_ready=1 constant, register file preloaded with x[i]=32'h1000_0000+i.
  - Required: first bytes 00,10,00,00,00, then 01,10,00,00,01, etc.
  - 160 transfers in total; last frame 1F,10,00,00,1F.
  - done pulses once, 192 cycles after start; busy/cpu_halt high for exactly that window.
- Backpressure: tx_ready toggles 1,0,0,1 repeatedly, with x5=32'hDEAD_BEEF.
  - Required: tx_data is stable whenever valid&!ready.
  - Frame for index 5 is 05,DE,AD,BE,EF, with no byte lost or duplicated.
- Start while busy: start pulsed again at cycle 50 of a dump.
  - Required: ignored; exactly 160 bytes and one done pulse.
- Reset mid-dump: rst=1 for one cycle while the 3rd byte of register 7 is pending.
  - Required: tx_valid=0 and busy=0 on the next cycle, rd_addr=0, no done pulse.
  - A later start restarts the dump from index 0.
- Back-to-back: start asserted in the done-pulse cycle.
  - Required: a second full dump of 160 bytes, beginning with index byte 00.
- Parameter variant: NUM_REGS=4, DATA_W=16.
  - Required: frames of 3 bytes, 12 bytes total, done after 4*4=16 cycles.
